// File: rtl/seq_mult_bcd_display.sv
// Sequential shift-add multiplier with double-dabble binary-to-BCD
// conversion and active-low seven-segment output encoding.
// The operation runs as: capture -> WIDTH shift-add cycles -> one load cycle
// -> 2*WIDTH double-dabble cycles -> one-cycle DONE. That gives done in the
// cycle after edge 3*WIDTH+1 when start is sampled at edge 0.
module seq_mult_bcd_display #(
  parameter int WIDTH    = 4,
  parameter int DIGITS   = 3,
  parameter int BLANK_LZ = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      A,
  input  logic [WIDTH-1:0]      B,
  output logic                  busy,
  output logic                  done,
  output logic [2*WIDTH-1:0]    product,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int PW = 2 * WIDTH;
  localparam int BW = 4 * DIGITS;
  localparam int SW = 7 * DIGITS;
  localparam int CW = $clog2(PW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    BCD  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [CW-1:0]   cnt_r;
  logic [PW-1:0]   mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [PW-1:0]   acc_r;
  logic [PW-1:0]   bin_r;
  logic [BW-1:0]   bcd_r;
  logic [BW-1:0]   bcd_adj_s;
  logic [BW-1:0]   bcd_next_s;
  logic [PW-1:0]   bin_next_s;
  logic [SW-1:0]   seg_reset_s;
  logic            mul_last_s;
  logic            bcd_last_s;

  // Seven-segment pattern for one decimal digit, g..a, active low.
  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Double-dabble correction: add 3 to every nibble that is 5 or more.
  function automatic logic [BW-1:0] dabble_adjust(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = r[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Encode all BCD digits; optionally blank zeros above the leading digit.
  function automatic logic [SW-1:0] seg_encode(input logic [BW-1:0] v);
    logic [SW-1:0] s;
    logic          lead;
    s    = {SW{1'b1}};
    lead = (BLANK_LZ != 0);
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if ((i > 0) && lead && (v[4*i +: 4] == 4'd0)) begin
        s[7*i +: 7] = 7'b1111111;
      end else begin
        lead        = 1'b0;
        s[7*i +: 7] = digit_seg(v[4*i +: 4]);
      end
    end
    return s;
  endfunction

  assign seg_reset_s = seg_encode({BW{1'b0}});
  assign mul_last_s  = (state_r == MUL) && (cnt_r == CW'(WIDTH - 1));
  assign bcd_last_s  = (state_r == BCD) && (cnt_r == CW'(PW));

  // One double-dabble step: correct the nibbles, then shift BCD:binary left.
  always_comb begin
    bcd_adj_s                = dabble_adjust(bcd_r);
    {bcd_next_s, bin_next_s} = {bcd_adj_s, bin_r} << 1;
  end

  // Next-state selection for the operation sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = MUL;
        else       state_s = IDLE;
      end
      MUL: begin
        if (mul_last_s) state_s = BCD;
        else            state_s = MUL;
      end
      BCD: begin
        if (bcd_last_s) state_s = DONE;
        else            state_s = BCD;
      end
      DONE: begin
        if (start) state_s = MUL;
        else       state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= {CW{1'b0}};
      mcand_r  <= {PW{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {PW{1'b0}};
      bin_r    <= {PW{1'b0}};
      bcd_r    <= {BW{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= {PW{1'b0}};
      seg      <= seg_reset_s;
    end else begin
      state_r <= state_s;
      busy    <= (state_s == MUL) || (state_s == BCD);
      done    <= (state_s == DONE);
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            mcand_r  <= {{WIDTH{1'b0}}, A};
            mplier_r <= B;
            acc_r    <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
          end
        end
        MUL: begin
          if (mplier_r[0]) acc_r <= acc_r + mcand_r;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          if (mul_last_s) cnt_r <= {CW{1'b0}};
          else            cnt_r <= cnt_r + CW'(1);
        end
        BCD: begin
          // Count 0 loads the finished product; counts 1..2*WIDTH convert it.
          if (cnt_r == {CW{1'b0}}) begin
            bin_r <= acc_r;
            bcd_r <= {BW{1'b0}};
          end else begin
            bin_r <= bin_next_s;
            bcd_r <= bcd_next_s;
          end
          cnt_r <= cnt_r + CW'(1);
          if (bcd_last_s) begin
            product <= acc_r;
            seg     <= seg_encode(bcd_next_s);
          end
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_bcd_display.sv
// Directed, table-driven bench for seq_mult_bcd_display: a 4-bit instance with
// default parameters and an 8-bit/5-digit instance with leading-zero blanking.
module tb_seq_mult_bcd_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] BL = 7'b1111111;

  logic        clk;
  logic        rst;
  logic        start4, start8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  prod4;
  logic [15:0] prod8;
  logic [20:0] seg4;
  logic [34:0] seg8;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        sel;   // 0 = 4-bit instance, 1 = 8-bit instance
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] prod;
    logic [34:0] seg;
  } vec_t;

  vec_t vecs[12];

  seq_mult_bcd_display #(.WIDTH(4), .DIGITS(3), .BLANK_LZ(0)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4),
    .busy(busy4), .done(done4), .product(prod4), .seg(seg4)
  );

  seq_mult_bcd_display #(.WIDTH(8), .DIGITS(5), .BLANK_LZ(1)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .product(prod8), .seg(seg8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_done(input logic sel);
    return sel ? done8 : done4;
  endfunction

  function automatic logic get_busy(input logic sel);
    return sel ? busy8 : busy4;
  endfunction

  function automatic logic [15:0] get_prod(input logic sel);
    return sel ? prod8 : {8'd0, prod4};
  endfunction

  function automatic logic [34:0] get_seg(input logic sel);
    return sel ? seg8 : {14'd0, seg4};
  endfunction

  // Start one multiply on the selected instance and check latency and results.
  task automatic run_vec(input int id, input vec_t v);
    int cyc;
    int lat;
    lat = v.sel ? 25 : 13;
    @(negedge clk);
    if (v.sel) begin
      a8 = v.a[7:0]; b8 = v.b[7:0]; start8 = 1'b1;
    end else begin
      a4 = v.a[3:0]; b4 = v.b[3:0]; start4 = 1'b1;
    end
    tick();
    start4 = 1'b0;
    start8 = 1'b0;
    check($sformatf("vec%0d busy_after_start", id), 64'(get_busy(v.sel)), 64'd1);
    cyc = 0;
    while (!get_done(v.sel) && cyc < 80) begin
      tick();
      cyc++;
    end
    check($sformatf("vec%0d latency", id), 64'(cyc), 64'(lat));
    check($sformatf("vec%0d busy_at_done", id), 64'(get_busy(v.sel)), 64'd0);
    check($sformatf("vec%0d product", id), 64'(get_prod(v.sel)), 64'(v.prod));
    check($sformatf("vec%0d seg", id), 64'(get_seg(v.sel)), 64'(v.seg));
    tick();
    check($sformatf("vec%0d done_one_cycle", id), 64'(get_done(v.sel)), 64'd0);
    check($sformatf("vec%0d product_hold", id), 64'(get_prod(v.sel)), 64'(v.prod));
  endtask

  initial begin
    int cyc;
    int done_cnt;

    vecs[0]  = '{1'b0, 16'd3,   16'd4,   16'd12,    {14'd0, S0, S1, S2}};
    vecs[1]  = '{1'b0, 16'd11,  16'd11,  16'd121,   {14'd0, S1, S2, S1}};
    vecs[2]  = '{1'b0, 16'd15,  16'd15,  16'd225,   {14'd0, S2, S2, S5}};
    vecs[3]  = '{1'b0, 16'd0,   16'd9,   16'd0,     {14'd0, S0, S0, S0}};
    vecs[4]  = '{1'b0, 16'd7,   16'd0,   16'd0,     {14'd0, S0, S0, S0}};
    vecs[5]  = '{1'b0, 16'd1,   16'd1,   16'd1,     {14'd0, S0, S0, S1}};
    vecs[6]  = '{1'b0, 16'd9,   16'd7,   16'd63,    {14'd0, S0, S6, S3}};
    vecs[7]  = '{1'b0, 16'd13,  16'd14,  16'd182,   {14'd0, S1, S8, S2}};
    vecs[8]  = '{1'b1, 16'd255, 16'd255, 16'd65025, {S6, S5, S0, S2, S5}};
    vecs[9]  = '{1'b1, 16'd1,   16'd7,   16'd7,     {BL, BL, BL, BL, S7}};
    vecs[10] = '{1'b1, 16'd100, 16'd10,  16'd1000,  {BL, S1, S0, S0, S0}};
    vecs[11] = '{1'b1, 16'd0,   16'd0,   16'd0,     {BL, BL, BL, BL, S0}};

    rst = 1'b1;
    start4 = 1'b0; start8 = 1'b0;
    a4 = 4'd0; b4 = 4'd0; a8 = 8'd0; b8 = 8'd0;
    repeat (3) tick();

    // Reset state of both instances.
    check("rst4_seg",  64'(seg4),  64'({S0, S0, S0}));
    check("rst4_prod", 64'(prod4), 64'd0);
    check("rst4_busy", 64'(busy4), 64'd0);
    check("rst4_done", 64'(done4), 64'd0);
    check("rst8_seg",  64'(seg8),  64'({BL, BL, BL, BL, S0}));
    check("rst8_prod", 64'(prod8), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_vec(i, vecs[i]);
    end

    // start held high, operands changed mid-run, restart from DONE.
    @(negedge clk);
    a4 = 4'd5; b4 = 4'd6; start4 = 1'b1;
    tick();
    cyc = 0;
    repeat (2) begin
      tick();
      cyc++;
    end
    a4 = 4'd15; b4 = 4'd15;
    while (!done4 && cyc < 80) begin
      tick();
      cyc++;
    end
    check("hold_latency", 64'(cyc), 64'd13);
    check("hold_product", 64'(prod4), 64'd30);
    check("hold_seg",     64'(seg4),  64'({S0, S3, S0}));
    tick();
    check("restart_busy", 64'(busy4), 64'd1);
    check("restart_done", 64'(done4), 64'd0);
    start4 = 1'b0;
    cyc = 0;
    while (!done4 && cyc < 80) begin
      tick();
      cyc++;
    end
    check("restart_latency", 64'(cyc), 64'd13);
    check("restart_product", 64'(prod4), 64'd225);
    check("restart_seg",     64'(seg4),  64'({S2, S2, S5}));
    tick();

    // Reset in cycle 5 of an operation aborts it with no done pulse.
    @(negedge clk);
    a4 = 4'd9; b4 = 4'd9; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 64'(busy4), 64'd0);
    check("abort_prod", 64'(prod4), 64'd0);
    check("abort_seg",  64'(seg4),  64'({S0, S0, S0}));
    done_cnt = 0;
    repeat (20) begin
      tick();
      if (done4) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);

    // Reset wins over start on the same edge.
    @(negedge clk);
    a4 = 4'd7; b4 = 4'd7; start4 = 1'b1; rst = 1'b1;
    tick();
    check("prio_busy", 64'(busy4), 64'd0);
    @(negedge clk);
    start4 = 1'b0; rst = 1'b0;
    tick();
    check("prio_idle", 64'(busy4), 64'd0);

    run_vec(100, '{1'b0, 16'd2, 16'd3, 16'd6, {14'd0, S0, S0, S6}});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
